// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side VGA timing decoder. Registers hsync/vsync/RGB on the pixel
//   clock, measures line period, frame height and both sync pulse widths,
//   locks once consecutive frames agree, and while locked emits per-pixel
//   x/y coordinates with a valid strobe for the active window.
// Ports
//   dclk        pixel clock (only clock)
//   clr         synchronous active-high reset
//   hsync_in    horizontal sync, active low
//   vsync_in    vertical sync, active low
//   red_in      red pixel data [2:0]
//   green_in    green pixel data [2:0]
//   blue_in     blue pixel data [1:0]
//   pix_valid   active-window pixel strobe (locked only)
//   pix_x       hcnt - H_START, held when pix_valid is low
//   pix_y       vcnt - V_START, held when pix_valid is low
//   pix_data    {red,green,blue} of the same sample
//   line_len    last measured hsync period, dclk cycles
//   frame_lines last measured lines per frame
//   hpulse_len  last measured hsync low width, dclk cycles
//   vpulse_len  last measured vsync low width, lines
//   locked      timing locked
//   sync_err    one-cycle pulse on a timing violation while locked
module vga_sync_decoder #(
   parameter int CNT_W       = 10,
   parameter int H_START     = 144,
   parameter int H_ACTIVE    = 640,
   parameter int V_START     = 31,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic             dclk,
   input  logic             clr,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic [2:0]       red_in,
   input  logic [2:0]       green_in,
   input  logic [1:0]       blue_in,
   output logic             pix_valid,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic [7:0]       pix_data,
   output logic [CNT_W-1:0] line_len,
   output logic [CNT_W-1:0] frame_lines,
   output logic [CNT_W-1:0] hpulse_len,
   output logic [CNT_W-1:0] vpulse_len,
   output logic             locked,
   output logic             sync_err
);

   localparam int MW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W-1:0] HS   = CNT_W'(H_START);
   localparam logic [CNT_W-1:0] HE   = CNT_W'(H_START + H_ACTIVE);
   localparam logic [CNT_W-1:0] VS   = CNT_W'(V_START);
   localparam logic [CNT_W-1:0] VE   = CNT_W'(V_START + V_ACTIVE);
   localparam logic [MW-1:0]    LFV  = MW'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
   state_t state;

   logic             s_hsync, s_vsync, s_hsync_d, s_vsync_d;
   logic [7:0]       s_rgb;
   logic [CNT_W-1:0] hcnt, vcnt, vpcnt, ref_line, ref_frame;
   logic             vpend;
   logic [MW-1:0]    mcnt;

   logic             hfall, hrise, vfall, vrise, fstart, hsat, in_win;
   logic [CNT_W-1:0] hcnt_nx, vcnt_nx, line_meas, frame_meas;

   // The counters are advanced combinationally from the stage-1 sample so
   // that hcnt_nx/vcnt_nx describe the sample currently in s_*; the output
   // register then carries that same sample, giving the 2-cycle latency.
   always_comb begin
      hfall      = s_hsync_d & ~s_hsync;
      hrise      = ~s_hsync_d & s_hsync;
      vfall      = s_vsync_d & ~s_vsync;
      vrise      = ~s_vsync_d & s_vsync;
      fstart     = hfall & (vpend | vfall);
      line_meas  = hcnt + CNT_W'(1);
      frame_meas = vcnt + CNT_W'(1);
      hcnt_nx    = hfall ? '0 : ((hcnt == CMAX) ? CMAX : line_meas);
      vcnt_nx    = vcnt;
      if (fstart)
         vcnt_nx = '0;
      else if (hfall)
         vcnt_nx = (vcnt == CMAX) ? CMAX : frame_meas;
      hsat       = (hcnt_nx == CMAX);
      in_win     = (hcnt_nx >= HS) && (hcnt_nx < HE) &&
                   (vcnt_nx >= VS) && (vcnt_nx < VE);
   end

   always_ff @(posedge dclk) begin
      if (clr) begin
         s_hsync     <= 1'b0;
         s_vsync     <= 1'b0;
         s_hsync_d   <= 1'b0;
         s_vsync_d   <= 1'b0;
         s_rgb       <= '0;
         hcnt        <= '0;
         vcnt        <= '0;
         vpcnt       <= '0;
         vpend       <= 1'b0;
         ref_line    <= '0;
         ref_frame   <= '0;
         mcnt        <= '0;
         state       <= SEARCH;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_data    <= '0;
         line_len    <= '0;
         frame_lines <= '0;
         hpulse_len  <= '0;
         vpulse_len  <= '0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         s_hsync   <= hsync_in;
         s_vsync   <= vsync_in;
         s_rgb     <= {red_in, green_in, blue_in};
         s_hsync_d <= s_hsync;
         s_vsync_d <= s_vsync;
         hcnt      <= hcnt_nx;
         vcnt      <= vcnt_nx;

         if (hfall) line_len   <= line_meas;
         if (hrise) hpulse_len <= line_meas;

         if (fstart) begin
            frame_lines <= frame_meas;
            vpend       <= 1'b0;
         end else if (vfall) begin
            vpend       <= 1'b1;
         end

         // Count hsync falls while vsync is low; a fall coinciding with the
         // vsync fall already counts as the first line of the pulse.
         if (vfall)
            vpcnt <= hfall ? CNT_W'(1) : '0;
         else if (!s_vsync && hfall && vpcnt != CMAX)
            vpcnt <= vpcnt + CNT_W'(1);
         if (vrise) vpulse_len <= vpcnt;

         pix_valid <= (state == LOCKED) && in_win;
         pix_data  <= s_rgb;
         if ((state == LOCKED) && in_win) begin
            pix_x <= hcnt_nx - HS;
            pix_y <= vcnt_nx - VS;
         end

         sync_err <= 1'b0;
         case (state)
            SEARCH: begin
               if (fstart) begin
                  state     <= MEASURE;
                  mcnt      <= '0;
                  ref_line  <= line_meas;
                  ref_frame <= frame_meas;
               end
            end
            MEASURE: begin
               if (hsat) begin
                  state <= SEARCH;
               end else if (fstart) begin
                  ref_line  <= line_meas;
                  ref_frame <= frame_meas;
                  if (line_meas == ref_line && frame_meas == ref_frame) begin
                     mcnt <= mcnt + MW'(1);
                     if (mcnt + MW'(1) == LFV) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     mcnt <= '0;
                  end
               end
            end
            LOCKED: begin
               if (hsat || (hfall && line_meas != line_len) ||
                   (fstart && frame_meas != frame_lines)) begin
                  sync_err <= 1'b1;
                  locked   <= 1'b0;
                  state    <= SEARCH;
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//   Directed bench for vga_sync_decoder using a reduced timing (40-cycle
//   lines, 20-line frames) so several frames fit in a short run. Each tick
//   drives one pixel sample; the DUT's outputs for a sample appear one tick
//   later and are compared against the sample's own coordinates.
module tb_vga_sync_decoder;
   localparam int CW = 10, HS = 10, HA = 24, VS = 4, VA = 12, LF = 2;
   localparam int HL = 40, HP = 6, VL = 20, VP = 2;

   logic          dclk = 1'b0;
   logic          clr = 1'b1;
   logic          hsync_in = 1'b1;
   logic          vsync_in = 1'b1;
   logic [2:0]    red_in = '0;
   logic [2:0]    green_in = '0;
   logic [1:0]    blue_in = '0;
   logic          pix_valid, locked, sync_err;
   logic [CW-1:0] pix_x, pix_y, line_len, frame_lines, hpulse_len, vpulse_len;
   logic [7:0]    pix_data;

   int tests = 0, fails = 0;
   bit chk_pix = 1'b0;
   int pix_err, nvalid, maxx, maxy;
   int stray = 0, errs = 0, e0, err_h;
   int d1_h = -1, d1_v = -1;

   always #5 dclk = ~dclk;

   vga_sync_decoder #(.CNT_W(CW), .H_START(HS), .H_ACTIVE(HA), .V_START(VS),
                      .V_ACTIVE(VA), .LOCK_FRAMES(LF)) dut (
      .dclk(dclk), .clr(clr), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
      .line_len(line_len), .frame_lines(frame_lines), .hpulse_len(hpulse_len),
      .vpulse_len(vpulse_len), .locked(locked), .sync_err(sync_err)
   );

   function automatic logic [7:0] rgb_of(input int h, input int v);
      if (h == HS && v == VS) return 8'hA5;
      return 8'(h * 7 + v * 13);
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int h, input int v);
      logic w;
      hsync_in = (h < HP) ? 1'b0 : 1'b1;
      vsync_in = (v < VP) ? 1'b0 : 1'b1;
      {red_in, green_in, blue_in} = rgb_of(h, v);
      @(posedge dclk);
      #1;
      if (sync_err === 1'b1) errs++;
      if (d1_h >= 0) begin
         w = (d1_h >= HS && d1_h < HS + HA && d1_v >= VS && d1_v < VS + VA);
         if (chk_pix) begin
            if (pix_valid !== w) pix_err++;
            if (w) begin
               nvalid++;
               if (pix_x !== CW'(d1_h - HS) || pix_y !== CW'(d1_v - VS) ||
                   pix_data !== rgb_of(d1_h, d1_v)) pix_err++;
               if (int'(pix_x) > maxx) maxx = int'(pix_x);
               if (int'(pix_y) > maxy) maxy = int'(pix_y);
            end
            if (d1_h == HS && d1_v == VS)
               check("first_pix", 128'({pix_valid, pix_x, pix_y, pix_data}),
                     128'({1'b1, 10'd0, 10'd0, 8'hA5}));
         end else if (pix_valid !== 1'b0) begin
            stray++;
         end
      end
      d1_h = h;
      d1_v = v;
   endtask

   task automatic drive_line(input int v, input int hfrom, input int len);
      for (int h = hfrom; h < len; h++) tick(h, v);
   endtask

   task automatic drive_frame();
      for (int v = 0; v < VL; v++) drive_line(v, 0, HL);
   endtask

   task automatic clear_pix();
      pix_err = 0; nvalid = 0; maxx = -1; maxy = -1;
   endtask

   task automatic check_pix(input string tag);
      check({tag, "_err"},   128'(pix_err), 128'(0));
      check({tag, "_count"}, 128'(nvalid),  128'(HA * VA));
      check({tag, "_maxx"},  128'(maxx),    128'(HA - 1));
      check({tag, "_maxy"},  128'(maxy),    128'(VA - 1));
   endtask

   task automatic check_meas(input string tag);
      check({tag, "_line_len"},    128'(line_len),    128'(HL));
      check({tag, "_frame_lines"}, 128'(frame_lines), 128'(VL));
      check({tag, "_hpulse_len"},  128'(hpulse_len),  128'(HP));
      check({tag, "_vpulse_len"},  128'(vpulse_len),  128'(VP));
   endtask

   task automatic check_lock_edge(input string tag);
      check({tag, "_before"}, 128'(locked), 128'(0));
      tick(0, 0);
      check({tag, "_at_fs"}, 128'(locked), 128'(0));
      tick(1, 0);
      check({tag, "_rise"}, 128'(locked), 128'(1));
   endtask

   initial begin
      // Reset
      repeat (3) @(posedge dclk);
      #1;
      check("reset_outputs", 128'({pix_valid, pix_x, pix_y, pix_data, line_len, frame_lines,
                                   hpulse_len, vpulse_len, locked, sync_err}), 128'(0));
      clr = 1'b0;
      repeat (5) tick(100, 100);

      // Acquisition: lock at the third frame start after the first one
      for (int f = 0; f < 3; f++) drive_frame();
      check_meas("acq");
      check_lock_edge("lock");

      // Locked pixel stream over one frame
      chk_pix = 1'b1;
      clear_pix();
      drive_line(0, 2, HL);
      for (int v = 1; v < VL; v++) drive_line(v, 0, HL);
      check_pix("frame1");

      // hsync and vsync fall together: new frame, same height, no error
      tick(0, 0);
      tick(1, 0);
      check("simul_frame_lines", 128'(frame_lines), 128'(VL));
      check("simul_locked", 128'(locked), 128'(1));

      // One short line while locked
      e0 = errs;
      drive_line(0, 2, HL);
      for (int v = 1; v < 8; v++) drive_line(v, 0, HL);
      drive_line(8, 0, HL - 1);
      chk_pix = 1'b0;
      tick(0, 9);
      check("short_no_err_yet", 128'({sync_err, locked}), 128'({1'b0, 1'b1}));
      tick(1, 9);
      check("short_err_pulse", 128'(sync_err), 128'(1));
      tick(2, 9);
      check("short_err_end", 128'({sync_err, locked}), 128'({1'b0, 1'b0}));
      drive_line(9, 3, HL);
      for (int v = 10; v < VL; v++) drive_line(v, 0, HL);
      drive_frame();
      drive_frame();
      check("short_err_count", 128'(errs - e0), 128'(1));
      check_lock_edge("relock");

      // hsync held high while locked
      chk_pix = 1'b1;
      clear_pix();
      drive_line(0, 2, HL);
      for (int v = 1; v < 5; v++) drive_line(v, 0, HL);
      e0 = errs;
      err_h = -1;
      for (int h = 0; h < 1100; h++) begin
         tick(h, 5);
         if (sync_err === 1'b1 && err_h < 0) err_h = h;
      end
      check("sat_err_tick", 128'(err_h), 128'(1024));
      check("sat_err_count", 128'(errs - e0), 128'(1));
      check("sat_unlocked", 128'(locked), 128'(0));
      check("sat_pix_err", 128'(pix_err), 128'(0));
      chk_pix = 1'b0;

      // clr mid-active-line
      for (int v = 0; v < 10; v++) drive_line(v, 0, HL);
      drive_line(10, 0, 20);
      clr = 1'b1;
      tick(20, 10);
      clr = 1'b0;
      check("clr_outputs", 128'({pix_valid, pix_x, pix_y, pix_data, line_len, frame_lines,
                                 hpulse_len, vpulse_len, locked, sync_err}), 128'(0));
      drive_line(10, 21, HL);
      for (int v = 11; v < VL; v++) drive_line(v, 0, HL);
      for (int f = 0; f < 3; f++) drive_frame();
      check_lock_edge("clr_relock");
      chk_pix = 1'b1;
      clear_pix();
      drive_line(0, 2, HL);
      for (int v = 1; v < VL; v++) drive_line(v, 0, HL);
      check_pix("frame2");
      check_meas("final");
      check("stray_valid", 128'(stray), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
